// File: rtl/dma_txn_splitter_if.sv
// Descriptor and burst-request handshake bundle for dma_txn_splitter.
// master: the splitter side (accepts descriptors, issues burst requests).
// slave:  the environment side (offers descriptors, accepts burst requests).
interface dma_txn_splitter_if #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BYTES_WIDTH = 32
);
  localparam int unsigned BPB = DATA_WIDTH / 8;

  logic                   desc_valid_i;
  logic                   desc_ready_o;
  logic [ADDR_WIDTH-1:0]  desc_addr_i;
  logic [BYTES_WIDTH-1:0] desc_bytes_i;
  logic                   desc_mode_i;

  logic                   req_valid_o;
  logic                   req_ready_i;
  logic [ADDR_WIDTH-1:0]  req_addr_o;
  logic [7:0]             req_alen_o;
  logic [2:0]             req_size_o;
  logic [BPB-1:0]         req_strb_o;
  logic                   req_mode_o;

  modport master (
    input  desc_valid_i, desc_addr_i, desc_bytes_i, desc_mode_i, req_ready_i,
    output desc_ready_o, req_valid_o, req_addr_o, req_alen_o, req_size_o, req_strb_o,
    output req_mode_o
  );

  modport slave (
    output desc_valid_i, desc_addr_i, desc_bytes_i, desc_mode_i, req_ready_i,
    input  desc_ready_o, req_valid_o, req_addr_o, req_alen_o, req_size_o, req_strb_o,
    input  req_mode_o
  );
endinterface

// File: rtl/dma_txn_splitter.sv
// Splits one DMA descriptor into legal AXI4 burst requests: 4KB boundary, max burst
// length and byte-lane masking for unaligned head/tail beats.
// Optional: define DMA_SPLIT_STATS_EN to enable the saturating per-descriptor burst counter.
module dma_txn_splitter #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BYTES_WIDTH = 32,
  parameter int unsigned MAX_BEATS   = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  dma_txn_splitter_if.master        bus,
  input  logic                      abort_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [15:0]               txn_cnt_o
);
  localparam int unsigned BPB  = DATA_WIDTH / 8;
  localparam int unsigned OffW = $clog2(BPB);
  localparam int unsigned CntW = BYTES_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] OffMask  = ADDR_WIDTH'(BPB - 1);
  localparam logic [ADDR_WIDTH-1:0] PageMask = ADDR_WIDTH'(4095);

  typedef enum logic [1:0] {StIdle, StCalc, StIssue, StDone} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [BYTES_WIDTH-1:0] rem_q, rem_d;
  logic [BYTES_WIDTH-1:0] used_q, used_d;
  logic                   mode_q, mode_d;
  logic                   abort_q, abort_d;
  logic                   req_valid_q, req_valid_d;
  logic [ADDR_WIDTH-1:0]  req_addr_q, req_addr_d;
  logic [7:0]             req_alen_q, req_alen_d;
  logic [2:0]             req_size_q, req_size_d;
  logic [BPB-1:0]         req_strb_q, req_strb_d;
  logic                   req_mode_q, req_mode_d;

  logic [CntW-1:0] off_c, rem_c, page_c, beats_c, used_c;
  logic [BPB-1:0]  strb_c;
  logic [7:0]      alen_c;

  function automatic logic [BPB-1:0] lane_mask(input logic [CntW-1:0] lo,
                                               input logic [CntW-1:0] hi);
    logic [BPB-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < BPB; i++) begin
      m[i] = (CntW'(i) >= lo) && (CntW'(i) <= hi);
    end
    return m;
  endfunction

  // Candidate burst for the current pointer/remainder.
  always_comb begin
    off_c   = CntW'(addr_q & OffMask);
    rem_c   = CntW'(rem_q);
    page_c  = (CntW'(4096) - CntW'(addr_q & PageMask)) >> OffW;
    beats_c = CntW'(1);
    used_c  = rem_c;
    strb_c  = '1;
    if (off_c + rem_c <= CntW'(BPB)) begin
      // Whole remainder in one beat; also covers aligned rem < BPB.
      strb_c = lane_mask(off_c, off_c + rem_c - CntW'(1));
    end else if (off_c != '0) begin
      used_c = CntW'(BPB) - off_c;
      strb_c = lane_mask(off_c, CntW'(BPB - 1));
    end else begin
      beats_c = rem_c >> OffW;
      if (mode_q) begin
        if (beats_c > CntW'(MAX_BEATS)) beats_c = CntW'(MAX_BEATS);
        if (beats_c > page_c)           beats_c = page_c;
      end else if (beats_c > CntW'(16)) begin
        beats_c = CntW'(16);
      end
      used_c = beats_c << OffW;
    end
    alen_c = 8'(beats_c - CntW'(1));
  end

  // Next-state and registered request fields.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    used_d      = used_q;
    mode_d      = mode_q;
    abort_d     = abort_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    req_alen_d  = req_alen_q;
    req_size_d  = req_size_q;
    req_strb_d  = req_strb_q;
    req_mode_d  = req_mode_q;
    case (state_q)
      StIdle: begin
        if (bus.desc_valid_i) begin
          addr_d  = bus.desc_addr_i;
          rem_d   = bus.desc_bytes_i;
          mode_d  = bus.desc_mode_i;
          abort_d = 1'b0;
          state_d = (bus.desc_bytes_i == '0) ? StDone : StCalc;
        end
      end
      StCalc: begin
        if (abort_q || abort_i) begin
          state_d = StDone;
        end else begin
          req_valid_d = 1'b1;
          req_addr_d  = addr_q & ~OffMask;
          req_alen_d  = alen_c;
          req_size_d  = 3'(OffW);
          req_strb_d  = strb_c;
          req_mode_d  = mode_q;
          used_d      = BYTES_WIDTH'(used_c);
          state_d     = StIssue;
        end
      end
      StIssue: begin
        // Valid is held until the handshake even when aborting.
        if (bus.req_ready_i) begin
          req_valid_d = 1'b0;
          rem_d       = rem_q - used_q;
          if (mode_q) addr_d = addr_q + ADDR_WIDTH'(used_q);
          state_d = ((rem_d == '0) || abort_q || abort_i) ? StDone : StCalc;
        end
      end
      StDone: begin
        abort_d = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if ((state_q == StCalc || state_q == StIssue) && abort_i) abort_d = 1'b1;
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      rem_q       <= '0;
      used_q      <= '0;
      mode_q      <= 1'b0;
      abort_q     <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_alen_q  <= '0;
      req_size_q  <= '0;
      req_strb_q  <= '0;
      req_mode_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      used_q      <= used_d;
      mode_q      <= mode_d;
      abort_q     <= abort_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      req_alen_q  <= req_alen_d;
      req_size_q  <= req_size_d;
      req_strb_q  <= req_strb_d;
      req_mode_q  <= req_mode_d;
    end
  end

  assign bus.desc_ready_o = (state_q == StIdle);
  assign bus.req_valid_o  = req_valid_q;
  assign bus.req_addr_o   = req_addr_q;
  assign bus.req_alen_o   = req_alen_q;
  assign bus.req_size_o   = req_size_q;
  assign bus.req_strb_o   = req_strb_q;
  assign bus.req_mode_o   = req_mode_q;
  assign busy_o           = (state_q != StIdle);
  assign done_o           = (state_q == StDone);

`ifdef DMA_SPLIT_STATS_EN
  logic [15:0] txn_cnt_q;

  // Bursts issued for the current descriptor; saturates, kept after done.
  always_ff @(posedge clk) begin
    if (rst) begin
      txn_cnt_q <= '0;
    end else if (state_q == StIdle && bus.desc_valid_i) begin
      txn_cnt_q <= '0;
    end else if (req_valid_q && bus.req_ready_i && txn_cnt_q != 16'hFFFF) begin
      txn_cnt_q <= txn_cnt_q + 16'd1;
    end
  end

  assign txn_cnt_o = txn_cnt_q;
`else
  assign txn_cnt_o = '0;
`endif
endmodule

// File: tb/tb_dma_txn_splitter.sv
// Scoreboard bench for dma_txn_splitter (DATA_WIDTH=32, MAX_BEATS=256).
module tb_dma_txn_splitter;
  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  alen;
    logic [3:0]  strb;
    logic        mode;
  } req_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        abort;
  logic        busy;
  logic        done;
  logic [15:0] txn_cnt;
  int          rmode;
  int          n_checks = 0;
  int          n_fails  = 0;
  req_t        exp_q[$];

  dma_txn_splitter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BYTES_WIDTH(32)) bus ();

  dma_txn_splitter #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .BYTES_WIDTH(32),
    .MAX_BEATS  (256)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.master),
    .abort_i  (abort),
    .busy_o   (busy),
    .done_o   (done),
    .txn_cnt_o(txn_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_cnt(input int n);
`ifdef DMA_SPLIT_STATS_EN
    return 16'(n);
`else
    return 16'(n & 0);
`endif
  endfunction

  task automatic push_req(input logic [31:0] a, input logic [7:0] l, input logic [3:0] s,
                          input logic m);
    req_t r;
    r.addr = a; r.alen = l; r.strb = s; r.mode = m;
    exp_q.push_back(r);
  endtask

  // Ready policy: 0 always ready, 1 random, 2 driven by the main sequence.
  always @(posedge clk) begin
    #1;
    if (rmode == 0)      bus.req_ready_i = 1'b1;
    else if (rmode == 1) bus.req_ready_i = 1'($urandom_range(0, 1));
  end

  // Scoreboard: compare every accepted burst request against the queue head.
  always @(negedge clk) begin
    req_t e;
    if (!rst && bus.req_valid_o && bus.req_ready_i) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_req", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("req_addr", bus.req_addr_o, e.addr);
        check_eq("req_alen", bus.req_alen_o, e.alen);
        check_eq("req_size", bus.req_size_o, 3'd2);
        check_eq("req_strb", bus.req_strb_o, e.strb);
        check_eq("req_mode", bus.req_mode_o, e.mode);
      end
    end
  end

  task automatic accept_desc(input logic [31:0] a, input logic [31:0] b, input logic m);
    int k;
    @(posedge clk); #1;
    bus.desc_valid_i = 1'b1;
    bus.desc_addr_i  = a;
    bus.desc_bytes_i = b;
    bus.desc_mode_i  = m;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.desc_ready_o && k < 50);
    check_eq("desc_accept", bus.desc_ready_o, 1);
    @(posedge clk); #1;
    // Scramble inputs: the descriptor must already be latched.
    bus.desc_valid_i = 1'b0;
    bus.desc_addr_i  = $urandom;
    bus.desc_bytes_i = $urandom;
    bus.desc_mode_i  = ~m;
  endtask

  task automatic wait_done(input int exp_lat, input int n_bursts);
    int k, lat;
    bit seen, any_valid;
    k = 0; lat = 0; seen = 0; any_valid = 0;
    while (!seen && k < 3000) begin
      @(negedge clk);
      k++;
      if (bus.req_valid_o) begin
        any_valid = 1;
        if (lat == 0) lat = k;
      end
      if (done) begin
        seen = 1;
        check_eq("busy_in_done", busy, 1);
      end
    end
    check_eq("done_seen", seen, 1);
    if (exp_lat == 0) begin
      check_eq("done_latency", k, 1);
      check_eq("no_req_valid", any_valid, 0);
    end else if (exp_lat > 0) begin
      check_eq("valid_latency", lat, exp_lat);
    end
    @(negedge clk);
    check_eq("done_one_cycle", done, 0);
    check_eq("busy_after_done", busy, 0);
    check_eq("ready_after_done", bus.desc_ready_o, 1);
    check_eq("sb_empty", exp_q.size(), 0);
    check_eq("txn_cnt", txn_cnt, exp_cnt(n_bursts));
  endtask

  initial begin
    int  k;
    bit  stray;
    rst              = 1'b1;
    abort            = 1'b0;
    rmode            = 0;
    bus.req_ready_i  = 1'b1;
    bus.desc_valid_i = 1'b0;
    bus.desc_addr_i  = '0;
    bus.desc_bytes_i = '0;
    bus.desc_mode_i  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_desc_ready", bus.desc_ready_o, 1);
    check_eq("rst_req_valid", bus.req_valid_o, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_req_addr", bus.req_addr_o, 0);
    check_eq("rst_req_alen", bus.req_alen_o, 0);
    check_eq("rst_req_strb", bus.req_strb_o, 0);
    check_eq("rst_txn_cnt", txn_cnt, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Aligned single burst.
    push_req(32'h1000, 8'd15, 4'hF, 1'b1);
    accept_desc(32'h1000, 32'd64, 1'b1);
    wait_done(2, 1);

    // Unaligned head and tail.
    push_req(32'h1000, 8'd0, 4'hC, 1'b1);
    push_req(32'h1004, 8'd0, 4'hF, 1'b1);
    push_req(32'h1008, 8'd0, 4'h3, 1'b1);
    accept_desc(32'h1002, 32'd8, 1'b1);
    wait_done(2, 3);

    // 4KB boundary split.
    push_req(32'h0FF0, 8'd3, 4'hF, 1'b1);
    push_req(32'h1000, 8'd3, 4'hF, 1'b1);
    accept_desc(32'h0FF0, 32'd32, 1'b1);
    wait_done(2, 2);

    // MAX_BEATS split, random backpressure.
    rmode = 1;
    push_req(32'h0000, 8'd255, 4'hF, 1'b1);
    push_req(32'h0400, 8'd255, 4'hF, 1'b1);
    accept_desc(32'h0000, 32'd2048, 1'b1);
    wait_done(2, 2);

    // Unaligned head across a 4KB page, random backpressure.
    push_req(32'h0FFC, 8'd0, 4'hC, 1'b1);
    push_req(32'h1000, 8'd1, 4'hF, 1'b1);
    accept_desc(32'h0FFE, 32'd10, 1'b1);
    wait_done(2, 2);
    rmode = 0;

    // Zero-length descriptor.
    accept_desc(32'h1234, 32'd0, 1'b1);
    wait_done(0, 0);

    // Small transfer inside one beat.
    push_req(32'h1000, 8'd0, 4'h6, 1'b1);
    accept_desc(32'h1001, 32'd2, 1'b1);
    wait_done(2, 1);

    // FIXED: capped at 16 beats, address does not advance.
    push_req(32'h2000, 8'd15, 4'hF, 1'b0);
    push_req(32'h2000, 8'd3, 4'hF, 1'b0);
    accept_desc(32'h2000, 32'd80, 1'b0);
    wait_done(2, 2);

    // Abort while stalled: fields stay stable, one burst only, then done.
    rmode = 2;
    @(posedge clk); #1 bus.req_ready_i = 1'b0;
    push_req(32'h0000, 8'd255, 4'hF, 1'b1);
    accept_desc(32'h0000, 32'd2048, 1'b1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.req_valid_o && k < 20);
    check_eq("abort_valid_up", bus.req_valid_o, 1);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1 abort = (c == 2);
      @(negedge clk);
      check_eq("stall_valid", bus.req_valid_o, 1);
      check_eq("stall_addr", bus.req_addr_o, 32'h0);
      check_eq("stall_alen", bus.req_alen_o, 8'd255);
      check_eq("stall_strb", bus.req_strb_o, 4'hF);
    end
    @(posedge clk); #1;
    abort = 1'b0;
    bus.req_ready_i = 1'b1;
    wait_done(-1, 1);
    stray = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.req_valid_o) stray = 1;
    end
    check_eq("no_req_after_abort", stray, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
